// File: rtl/m_prs_cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states and address-width helper.
package m_prs_cpu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ANDI = 4'h4,
    OP_ORI  = 4'h5,
    OP_XORI = 4'h6,
    OP_IN   = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_NOP2 = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/m_prs_acc_cpu_if.sv
// Switch/LED, program-load and control bundle of the accumulator CPU.
// Carries step_mode/step only when M_PRS_CPU_STEP_EN is defined.
interface m_prs_acc_cpu_if
  import m_prs_cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMEM_DEPTH = 16
);
  localparam int unsigned AW      = addr_w(IMEM_DEPTH);
  localparam int unsigned INSTR_W = OP_W + DATA_W;

  logic [DATA_W-1:0]  sw_in;
  logic [DATA_W-1:0]  led_out;
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               run;
  logic               stop;
  logic [AW-1:0]      pc;
  logic               halted;
  logic               busy;
`ifdef M_PRS_CPU_STEP_EN
  logic               step_mode;
  logic               step;

  modport master (output sw_in, prog_we, prog_addr, prog_data, run, stop, step_mode, step,
                  input  led_out, pc, halted, busy);
  modport slave  (input  sw_in, prog_we, prog_addr, prog_data, run, stop, step_mode, step,
                  output led_out, pc, halted, busy);
`else
  modport master (output sw_in, prog_we, prog_addr, prog_data, run, stop,
                  input  led_out, pc, halted, busy);
  modport slave  (input  sw_in, prog_we, prog_addr, prog_data, run, stop,
                  output led_out, pc, halted, busy);
`endif

endinterface

// File: rtl/m_prs_alu.sv
// Combinational ALU: computes the accumulator and Z/C results of one instruction.
module m_prs_alu
  import m_prs_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] sw,
  input  logic              c_in,
  output logic [DATA_W-1:0] acc_c,
  output logic              c_c,
  output logic              z_c,
  output logic              acc_we_c
);

  logic [DATA_W:0] sum;

  always_comb begin
    acc_c    = acc;
    c_c      = c_in;
    acc_we_c = 1'b0;
    sum      = '0;
    unique case (op)
      OP_LDI:  begin acc_c = imm;       acc_we_c = 1'b1; end
      OP_ADDI: begin
        sum      = {1'b0, acc} + {1'b0, imm};
        acc_c    = sum[DATA_W-1:0];
        c_c      = sum[DATA_W];
        acc_we_c = 1'b1;
      end
      // Top bit of the widened difference is the borrow
      OP_SUBI: begin
        sum      = {1'b0, acc} - {1'b0, imm};
        acc_c    = sum[DATA_W-1:0];
        c_c      = sum[DATA_W];
        acc_we_c = 1'b1;
      end
      OP_ANDI: begin acc_c = acc & imm; acc_we_c = 1'b1; end
      OP_ORI:  begin acc_c = acc | imm; acc_we_c = 1'b1; end
      OP_XORI: begin acc_c = acc ^ imm; acc_we_c = 1'b1; end
      OP_IN:   begin acc_c = sw;        acc_we_c = 1'b1; end
      OP_SHL:  begin
        c_c      = acc[DATA_W-1];
        acc_c    = {acc[DATA_W-2:0], 1'b0};
        acc_we_c = 1'b1;
      end
      OP_SHR:  begin
        c_c      = acc[0];
        acc_c    = {1'b0, acc[DATA_W-1:1]};
        acc_we_c = 1'b1;
      end
      default: ;
    endcase
    z_c = (acc_c == '0);
  end

endmodule

// File: rtl/m_prs_acc_cpu.sv
// Accumulator CPU core: program RAM, two-cycle fetch/execute FSM, Z/C flags, LED output.
// Optional single-step fetch gating under M_PRS_CPU_STEP_EN.
module m_prs_acc_cpu
  import m_prs_cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMEM_DEPTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  m_prs_acc_cpu_if.slave bus
);

  localparam int unsigned AW      = addr_w(IMEM_DEPTH);
  localparam int unsigned INSTR_W = OP_W + DATA_W;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] mem [IMEM_DEPTH];
  logic [INSTR_W-1:0] ir;
  logic [AW-1:0]      pc_q;
  logic [AW-1:0]      pc_inc;
  logic [AW-1:0]      jmp_tgt;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  led_q;
  logic               flag_z, flag_c;
  logic               halted_q, busy_q;
  opcode_e            op;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  alu_acc_c;
  logic               alu_c_c, alu_z_c, alu_we_c;
  logic               fetch_stall_c;
  logic               restart_c;

  assign op      = opcode_e'(ir[INSTR_W-1:DATA_W]);
  assign imm     = ir[DATA_W-1:0];
  assign pc_inc  = pc_q + AW'(1);
  assign jmp_tgt = AW'(imm);

`ifdef M_PRS_CPU_STEP_EN
  assign fetch_stall_c = bus.step_mode && !bus.step;
`else
  assign fetch_stall_c = 1'b0;
`endif

  m_prs_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op),
    .acc     (acc),
    .imm     (imm),
    .sw      (bus.sw_in),
    .c_in    (flag_c),
    .acc_c   (alu_acc_c),
    .c_c     (alu_c_c),
    .z_c     (alu_z_c),
    .acc_we_c(alu_we_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; stop overrides everything, including a pending restart
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.run) begin state_d = ST_FETCH; restart_c = 1'b1; end
      ST_FETCH: if (!fetch_stall_c) state_d = ST_EXEC;
      ST_EXEC:  state_d = (op == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  if (bus.run) begin state_d = ST_FETCH; restart_c = 1'b1; end
      default:  state_d = ST_IDLE;
    endcase
    if (bus.stop) begin
      state_d   = ST_IDLE;
      restart_c = 1'b0;
    end
  end

  // Program RAM: written only while idle, read synchronously in FETCH
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      pc_q     <= '0;
      acc      <= '0;
      led_q    <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      halted_q <= (state_d == ST_HALT);
      busy_q   <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
      if (restart_c) begin
        pc_q   <= '0;
        acc    <= '0;
        flag_z <= 1'b0;
        flag_c <= 1'b0;
      end else if (!bus.stop) begin
        if (state_q == ST_FETCH && !fetch_stall_c) ir <= mem[pc_q];
        if (state_q == ST_EXEC) begin
          if (alu_we_c) begin
            acc    <= alu_acc_c;
            flag_z <= alu_z_c;
          end
          flag_c <= alu_c_c;
          if (op == OP_OUT) led_q <= acc;
          case (op)
            OP_JMP:  pc_q <= jmp_tgt;
            OP_JZ:   pc_q <= flag_z ? jmp_tgt : pc_inc;
            OP_JC:   pc_q <= flag_c ? jmp_tgt : pc_inc;
            OP_HLT:  pc_q <= pc_q;
            default: pc_q <= pc_inc;
          endcase
        end
      end
    end
  end

  assign bus.led_out = led_q;
  assign bus.pc      = pc_q;
  assign bus.halted  = halted_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_m_prs_acc_cpu.sv
// Directed self-checking bench for m_prs_acc_cpu with hand-computed expectations.
module tb_m_prs_acc_cpu;
  import m_prs_cpu_pkg::*;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IMEM_DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  m_prs_acc_cpu_if #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH)) cpu_if ();

  m_prs_acc_cpu #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (cpu_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input opcode_e op, input logic [7:0] imm);
    cpu_if.prog_we   = 1'b1;
    cpu_if.prog_addr = 4'(addr);
    cpu_if.prog_data = {op, imm};
    @(negedge clk);
    cpu_if.prog_we   = 1'b0;
  endtask

  task automatic run_pulse();
    cpu_if.run = 1'b1;
    @(negedge clk);
    cpu_if.run = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    cpu_if.stop = 1'b1;
    @(negedge clk);
    cpu_if.stop = 1'b0;
    chk({tag, "_busy"},   32'(cpu_if.busy),   32'd0);
    chk({tag, "_halted"}, 32'(cpu_if.halted), 32'd0);
  endtask

  task automatic wait_halt(input int budget, output int cycles, output logic saw_zero);
    cycles   = 0;
    saw_zero = 1'b0;
    while (!cpu_if.halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (cpu_if.led_out == 8'h00) saw_zero = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic z0;

    cpu_if.sw_in     = '0;
    cpu_if.prog_we   = 1'b0;
    cpu_if.prog_addr = '0;
    cpu_if.prog_data = '0;
    cpu_if.run       = 1'b0;
    cpu_if.stop      = 1'b0;
`ifdef M_PRS_CPU_STEP_EN
    cpu_if.step_mode = 1'b0;
    cpu_if.step      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_led",    32'(cpu_if.led_out), 32'h0);
    chk("rst_pc",     32'(cpu_if.pc),      32'h0);
    chk("rst_halted", 32'(cpu_if.halted),  32'h0);
    chk("rst_busy",   32'(cpu_if.busy),    32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: LDI 5; ADDI 3; OUT; HLT
    load(0, OP_LDI, 8'h05);
    load(1, OP_ADDI, 8'h03);
    load(2, OP_OUT, 8'h00);
    load(3, OP_HLT, 8'h00);
    run_pulse();
    chk("t1_busy", 32'(cpu_if.busy), 32'd1);
    wait_halt(12, cyc, z0);
    chk("t1_latency", 32'(cyc),            32'd8);
    chk("t1_halted",  32'(cpu_if.halted),  32'd1);
    chk("t1_led",     32'(cpu_if.led_out), 32'h08);
    chk("t1_pc",      32'(cpu_if.pc),      32'd3);
    repeat (3) @(negedge clk);
    chk("t1_pc_hold", 32'(cpu_if.pc),      32'd3);
    load(0, OP_LDI, 8'h77);
    go_idle("t1_stop");

    // Test 2: carry-driven jump skips an OUT of 0x00
    load(0, OP_LDI, 8'hFF);
    load(1, OP_ADDI, 8'h01);
    load(2, OP_JC, 8'h04);
    load(3, OP_OUT, 8'h00);
    load(4, OP_LDI, 8'hAA);
    load(5, OP_OUT, 8'h00);
    load(6, OP_HLT, 8'h00);
    run_pulse();
    wait_halt(30, cyc, z0);
    chk("t2_halted", 32'(cpu_if.halted),  32'd1);
    chk("t2_led",    32'(cpu_if.led_out), 32'hAA);
    chk("t2_no_00",  32'(z0),             32'd0);
    chk("t2_c",      32'(dut.flag_c),     32'd1);
    chk("t2_z",      32'(dut.flag_z),     32'd0);
    chk("t2_pc",     32'(cpu_if.pc),      32'd6);
    go_idle("t2_stop");

    // Test 3: IN; SHR; OUT; HLT with sw_in=0x3C
    cpu_if.sw_in = 8'h3C;
    load(0, OP_IN, 8'h00);
    load(1, OP_SHR, 8'h00);
    load(2, OP_OUT, 8'h00);
    load(3, OP_HLT, 8'h00);
    run_pulse();
    wait_halt(20, cyc, z0);
    chk("t3_led", 32'(cpu_if.led_out), 32'h1E);
    chk("t3_c",   32'(dut.flag_c),     32'd0);
    chk("t3_z",   32'(dut.flag_z),     32'd0);

    // Test 5: async reset mid-run, then rerun from retained RAM
    go_idle("t5_pre");
    run_pulse();
    repeat (3) @(negedge clk);
    chk("t5_busy_before", 32'(cpu_if.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_led",    32'(cpu_if.led_out), 32'h0);
    chk("t5_rst_pc",     32'(cpu_if.pc),      32'h0);
    chk("t5_rst_busy",   32'(cpu_if.busy),    32'h0);
    chk("t5_rst_halted", 32'(cpu_if.halted),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pulse();
    wait_halt(20, cyc, z0);
    chk("t5_rerun_halted", 32'(cpu_if.halted),  32'd1);
    chk("t5_rerun_led",    32'(cpu_if.led_out), 32'h1E);
    go_idle("t5_stop");

    // Test 4: stop during EXEC suppresses the executing instruction
    load(0, OP_NOP, 8'h00);
    load(1, OP_JMP, 8'h00);
    run_pulse();
    @(negedge clk);
    cpu_if.stop = 1'b1;
    @(negedge clk);
    cpu_if.stop = 1'b0;
    chk("t4_busy", 32'(cpu_if.busy),    32'd0);
    chk("t4_pc",   32'(cpu_if.pc),      32'd0);
    chk("t4_led",  32'(cpu_if.led_out), 32'h1E);
    repeat (2) @(negedge clk);
    chk("t4_stay_idle", 32'(cpu_if.busy), 32'd0);

    // Test 7: remaining ALU ops and JZ
    load(0,  OP_LDI,  8'h0F);
    load(1,  OP_SUBI, 8'h10);
    load(2,  OP_XORI, 8'hF0);
    load(3,  OP_ANDI, 8'h3C);
    load(4,  OP_ORI,  8'h81);
    load(5,  OP_SHL,  8'h00);
    load(6,  OP_OUT,  8'h00);
    load(7,  OP_SUBI, 8'h1A);
    load(8,  OP_JZ,   8'h0A);
    load(9,  OP_HLT,  8'h00);
    load(10, OP_LDI,  8'h77);
    load(11, OP_OUT,  8'h00);
    load(12, OP_HLT,  8'h00);
    run_pulse();
    repeat (14) @(negedge clk);
    chk("t7_led_mid", 32'(cpu_if.led_out), 32'h1A);
    chk("t7_c_mid",   32'(dut.flag_c),     32'd1);
    wait_halt(30, cyc, z0);
    chk("t7_led", 32'(cpu_if.led_out), 32'h77);
    chk("t7_pc",  32'(cpu_if.pc),      32'd12);
    chk("t7_c",   32'(dut.flag_c),     32'd0);
    chk("t7_z",   32'(dut.flag_z),     32'd0);
    go_idle("t7_stop");

    // Test 6: all-NOP program wraps pc; prog_we while running is dropped
    for (int i = 0; i < int'(IMEM_DEPTH); i++) load(i, OP_NOP, 8'h00);
    run_pulse();
    cpu_if.prog_we   = 1'b1;
    cpu_if.prog_addr = 4'd0;
    cpu_if.prog_data = {OP_HLT, 8'h00};
    repeat (2) @(negedge clk);
    cpu_if.prog_we   = 1'b0;
    cyc = 0;
    while (cpu_if.pc != 4'd15 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reach_15", 32'(cpu_if.pc), 32'd15);
    cyc = 0;
    while (cpu_if.pc != 4'd0 && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_wrap_0", 32'(cpu_if.pc), 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_pc_after", 32'(cpu_if.pc),     32'd1);
    chk("t6_halted",   32'(cpu_if.halted), 32'd0);
    chk("t6_busy",     32'(cpu_if.busy),   32'd1);
    go_idle("t6_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/m_prs_acc_cpu.md
Name: m_prs_acc_cpu

Overview:
- Parametrised accumulator CPU core: the next generation of the team's switch-in/LED-out CPU top.
- Generic data width and program-memory depth; on-chip program RAM loaded through a write port.
- Two-cycle fetch/execute state machine with Z/C flags, conditional jumps and halt/restart.
- Instantiated inside the TinyTapeout top: switches drive sw_in, LEDs driven from led_out, uio pins carry the program port.

Parameters:
- DATA_W, 8, accumulator/immediate/switch/LED width (4..16).
- IMEM_DEPTH, 16, program RAM entries (power of 2, 4..64); AW = clog2(IMEM_DEPTH).
- INSTR_W, 4+DATA_W, derived instruction width; not overridden.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_in  in  DATA_W  switch inputs, sampled by IN.
- led_out  out  DATA_W  output register, written by OUT.
- prog_we  in  1  program write strobe, honoured only in IDLE.
- prog_addr  in  AW  program write address.
- prog_data  in  INSTR_W  instruction word: [INSTR_W-1:DATA_W] = opcode, [DATA_W-1:0] = imm.
- run  in  1  start pulse, sampled in IDLE/HALT.
- stop  in  1  synchronous abort to IDLE, any state.
- pc  out  AW  current program counter.
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH/EXEC.

Behaviour:
- Reset (async assert, sync release): state IDLE; pc, acc, Z, C, led_out = 0; halted = 0; busy = 0. Program RAM is not reset.
- IDLE:
  - prog_we writes mem[prog_addr] on the clock edge.
  - run=1 -> FETCH; pc, acc, Z, C cleared. led_out holds.
- FETCH (1 cycle): synchronous RAM read of mem[pc] into instruction register -> EXEC.
- EXEC (1 cycle): execute; default pc <= pc+1, wrapping IMEM_DEPTH-1 -> 0; -> FETCH unless HLT.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 ADDI: {C,acc}=acc+imm.
  - 3 SUBI: {C,acc}=acc-imm; C = borrow.
  - 4 ANDI, 5 ORI, 6 XORI.
  - 7 IN: acc=sw_in.
  - 8 OUT: led_out=acc (visible the cycle after EXEC).
  - 9 JMP: pc=imm[AW-1:0].
  - A JZ: jump if Z.
  - B JC: jump if C.
  - C SHL: C=acc[MSB], acc<<=1.
  - D SHR: C=acc[0], acc>>=1.
  - E NOP.
  - F HLT -> HALT; pc not incremented.
- Flags:
  - Z updated by every op that writes acc: Z = (new acc == 0).
  - C updated only by ADDI, SUBI, SHL, SHR; other ops preserve C.
  - Jumps and OUT leave both flags unchanged.
- Arithmetic is modulo 2^DATA_W; imm bits above AW are ignored for jumps.
- HALT:
  - halted=1; led_out, acc and pc hold.
  - run=1 -> restart as from IDLE (pc/acc/flags cleared, -> FETCH).
  - prog_we ignored.
- stop=1: -> IDLE next edge from any state; has priority over run and over the executing instruction (acc, flags, led_out and pc are not updated that cycle).
- prog_we outside IDLE is dropped, with no RAM change.
- run held high in FETCH/EXEC is ignored.
- Throughput: one instruction per 2 cycles. First EXEC occurs 2 cycles after the run edge.

Optional Feature:
- Macro M_PRS_CPU_STEP_EN.
- Defined: adds input ports step_mode (1) and step (1).
  - When step_mode=1, FETCH waits in place until step=1 is sampled, giving one instruction per step pulse.
  - busy stays 1 while waiting.
  - stop still aborts.
- Undefined: ports absent; FETCH never stalls.

Decomposition:
- Package m_prs_cpu_pkg:
  - opcode enum, 4 bits, values 0..F as above.
  - state enum: IDLE, FETCH, EXEC, HALT.
  - helper function for AW.
- Sub-module m_prs_alu (combinational): inputs op, acc, imm, C; outputs new acc, new C, new Z, acc_we.
- Program RAM inferred inline as a synchronous-read array.

Test Plan:
- Load LDI 5; ADDI 3; OUT; HLT, pulse run -> led_out=0x08 and halted=1 within 8 cycles; pc=3.
- LDI 0xFF; ADDI 1; JC 4; OUT; LDI 0xAA; OUT; HLT -> led_out=0xAA; C=1, Z=0 at halt; 0x00 is never output.
- sw_in=0x3C; IN; SHR; OUT; HLT -> led_out=0x1E, C=0.
- Program with JMP 0 looping forever, assert stop mid-EXEC -> IDLE next cycle, busy=0, led_out unchanged.
- Assert rst_n low while busy -> all outputs 0 immediately, without waiting for a clock edge; RAM contents retained, so rerun reproduces the result.
- Fill all IMEM_DEPTH slots with NOP, run -> pc wraps from IMEM_DEPTH-1 to 0; prog_we during run leaves mem unchanged.
